// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared defaults and Gray-code helpers for async_fifo_cdc.
package async_fifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;
  localparam int PMAX = 16;
  typedef logic [PMAX-1:0] ptr_t;
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = 1; i < PMAX; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/async_fifo_cdc_sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high clear.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  always_ff @(posedge i_clk or posedge i_clr)
    if (i_clr) {o_q, r_meta} <= '0;
    else {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/async_fifo_cdc.sv
// async_fifo_cdc: dual-clock FWFT byte FIFO into the byte_clk_i domain, Gray pointers + 2-FF sync.
// Define ASYNC_FIFO_CHECK_EN to compile in simulation-only misuse checks.
module async_fifo_cdc
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             byte_clk_i,
  input  logic             reset_i,
  input  logic             wr_clk_i,
  input  logic             wr_en_i,
  input  logic [DSIZE-1:0] wr_data_i,
  output logic             wr_full_o,
  output logic             wr_awfull_o,
  input  logic             rd_en_i,
  output logic [DSIZE-1:0] rd_data_o,
  output logic             rd_empty_o
);
  localparam int PW = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;
  logic [DSIZE-1:0] r_mem [DEPTH];
  logic w_wrel, w_rrel, w_wrst, w_rrst;
  // Reset asserts immediately but releases two local edges later in each domain.
  sync_2ff #(.W(1)) u_wrst (.i_clk(wr_clk_i), .i_clr(reset_i), .i_d(1'b1), .o_q(w_wrel));
  sync_2ff #(.W(1)) u_rrst (.i_clk(byte_clk_i), .i_clr(reset_i), .i_d(1'b1), .o_q(w_rrel));
  assign w_wrst = ~w_wrel;
  assign w_rrst = ~w_rrel;
  logic [PW-1:0] r_wbin, r_wgray, r_rbin, r_rgray;
  logic [PW-1:0] w_wbin_nxt, w_wgray_nxt, w_rbin_nxt, w_rgray_nxt;
  logic [PW-1:0] w_rgray_sync, w_wgray_sync, w_rbin_sync, w_fill;
  logic w_we, w_re;
  sync_2ff #(.W(PW)) u_r2w (.i_clk(wr_clk_i), .i_clr(w_wrst), .i_d(r_rgray), .o_q(w_rgray_sync));
  sync_2ff #(.W(PW)) u_w2r (.i_clk(byte_clk_i), .i_clr(w_rrst), .i_d(r_wgray), .o_q(w_wgray_sync));
  assign w_we = wr_en_i & ~wr_full_o;
  assign w_wbin_nxt = r_wbin + PW'(w_we);
  assign w_wgray_nxt = PW'(bin2gray(PMAX'(w_wbin_nxt)));
  assign w_rbin_sync = PW'(gray2bin(PMAX'(w_rgray_sync)));
  assign w_fill = w_wbin_nxt - w_rbin_sync;
  always_ff @(posedge wr_clk_i or posedge w_wrst)
    if (w_wrst) begin
      r_wbin      <= '0;
      r_wgray     <= '0;
      wr_full_o   <= 1'b0;
      wr_awfull_o <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_nxt;
      r_wgray     <= w_wgray_nxt;
      wr_full_o   <= w_wgray_nxt == {~w_rgray_sync[PW-1:PW-2], w_rgray_sync[PW-3:0]};
      wr_awfull_o <= w_fill >= PW'(DEPTH - AFULL_MARGIN);
    end
  always_ff @(posedge wr_clk_i)
    if (w_we) r_mem[r_wbin[ASIZE-1:0]] <= wr_data_i;
  assign w_re = rd_en_i & ~rd_empty_o;
  assign w_rbin_nxt = r_rbin + PW'(w_re);
  assign w_rgray_nxt = PW'(bin2gray(PMAX'(w_rbin_nxt)));
  always_ff @(posedge byte_clk_i or posedge w_rrst)
    if (w_rrst) begin
      r_rbin     <= '0;
      r_rgray    <= '0;
      rd_empty_o <= 1'b1;
    end else begin
      r_rbin     <= w_rbin_nxt;
      r_rgray    <= w_rgray_nxt;
      rd_empty_o <= w_rgray_nxt == w_wgray_sync;
    end
  assign rd_data_o = r_mem[r_rbin[ASIZE-1:0]];
`ifdef ASYNC_FIFO_CHECK_EN
  always @(posedge wr_clk_i)
    if (!w_wrst && wr_en_i && wr_full_o) $error("async_fifo_cdc: write while full");
  always @(posedge byte_clk_i)
    if (!w_rrst && rd_en_i && rd_empty_o) $error("async_fifo_cdc: read while empty");
`else
`endif
endmodule

// File: tb/tb_async_fifo_cdc.sv
// tb_async_fifo_cdc: scoreboard bench; writes push expected bytes, a read-side monitor pops and compares.
`timescale 1ns/1ps
module tb_async_fifo_cdc;
  logic       byte_clk_i = 1'b0;
  logic       wr_clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       rd_en_i = 1'b0;
  logic       wr_full_o, wr_awfull_o, rd_empty_o;
  logic [7:0] rd_data_o;
  async_fifo_cdc dut (
    .byte_clk_i(byte_clk_i), .reset_i(reset_i), .wr_clk_i(wr_clk_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .wr_full_o(wr_full_o),
    .wr_awfull_o(wr_awfull_o), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
    .rd_empty_o(rd_empty_o)
  );
  always #5 wr_clk_i = ~wr_clk_i;
  always #40.690 byte_clk_i = ~byte_clk_i;
  logic [7:0] q[$];
  logic [7:0] mon_exp;
  int n_cmp = 0, n_err = 0, n_push = 0, n_pop = 0;
  int rd_mode = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask
  always @(posedge byte_clk_i) begin
    #1;
    rd_en_i = rd_mode == 1 ? 1'b1 : rd_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  // A handshake seen here completes on the next byte_clk_i rising edge.
  always @(negedge byte_clk_i)
    if (!reset_i && rd_en_i && !rd_empty_o) begin
      n_pop++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_data: got %0h, expected no data", rd_data_o);
      end else begin
        mon_exp = q.pop_front();
        chk("rd_data", {24'h0, rd_data_o}, {24'h0, mon_exp});
      end
    end
  task automatic wr_byte(input logic [7:0] d, input bit accept);
    @(negedge wr_clk_i);
    wr_en_i = 1'b1;
    wr_data_i = d;
    if (accept) begin
      q.push_back(d);
      n_push++;
    end
    @(negedge wr_clk_i);
    wr_en_i = 1'b0;
  endtask
  task automatic drain(input string name);
    int t;
    t = 0;
    rd_mode = 1;
    while (q.size() > 0 && t < 400) begin
      @(negedge byte_clk_i);
      t++;
    end
    if (q.size() > 0) timeout(name);
    repeat (2) @(negedge byte_clk_i);
    chk({name, "_empty"}, {31'h0, rd_empty_o}, 32'h1);
    rd_mode = 0;
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, i, cyc;
    #200;
    chk("rst_empty", {31'h0, rd_empty_o}, 32'h1);
    chk("rst_full", {31'h0, wr_full_o}, 32'h0);
    chk("rst_afull", {31'h0, wr_awfull_o}, 32'h0);
    reset_i = 1'b0;
    repeat (5) @(negedge byte_clk_i);
    chk("idle_empty", {31'h0, rd_empty_o}, 32'h1);
    chk("idle_full", {31'h0, wr_full_o}, 32'h0);
    wr_byte(8'h11, 1);
    k = 0;
    while (rd_empty_o && k < 6) begin
      @(posedge byte_clk_i);
      k++;
      #1;
    end
    chk("empty_latency_ok", {31'h0, (!rd_empty_o && k <= 3)}, 32'h1);
    chk("fwft_head", {24'h0, rd_data_o}, 32'h11);
    wr_byte(8'h22, 1);
    wr_byte(8'h33, 1);
    drain("three");
    for (int j = 1; j <= 16; j++) begin
      wr_byte(8'hA0 + 8'(j), 1);
      chk($sformatf("afull_w%0d", j), {31'h0, wr_awfull_o}, {31'h0, j >= 14});
      chk($sformatf("full_w%0d", j), {31'h0, wr_full_o}, {31'h0, j == 16});
    end
    wr_byte(8'hEE, 0);
    chk("full_after_drop", {31'h0, wr_full_o}, 32'h1);
    drain("sixteen");
    repeat (6) @(negedge wr_clk_i);
    chk("full_released", {31'h0, wr_full_o}, 32'h0);
    chk("afull_released", {31'h0, wr_awfull_o}, 32'h0);
    rd_mode = 2;
    i = 0;
    cyc = 0;
    while (i < 1000 && cyc < 50000) begin
      @(negedge wr_clk_i);
      cyc++;
      if (!wr_full_o) begin
        wr_en_i = 1'b1;
        wr_data_i = 8'(i);
        q.push_back(8'(i));
        n_push++;
        i++;
      end else wr_en_i = 1'b0;
    end
    @(negedge wr_clk_i);
    wr_en_i = 1'b0;
    if (i < 1000) timeout("stream_write");
    drain("stream");
    chk("pop_count", n_pop, n_push);
    for (int j = 0; j < 5; j++) wr_byte(8'hC0 + 8'(j), 1);
    repeat (5) @(negedge byte_clk_i);
    #3;
    reset_i = 1'b1;
    #1;
    chk("midrst_empty", {31'h0, rd_empty_o}, 32'h1);
    chk("midrst_full", {31'h0, wr_full_o}, 32'h0);
    q.delete();
    n_push = n_pop;
    #100;
    reset_i = 1'b0;
    repeat (4) @(negedge byte_clk_i);
    chk("postrst_empty", {31'h0, rd_empty_o}, 32'h1);
    wr_byte(8'h5A, 1);
    drain("after_reset");
    rd_mode = 1;
    repeat (10) @(negedge byte_clk_i);
    chk("pop_empty_still_empty", {31'h0, rd_empty_o}, 32'h1);
    rd_mode = 0;
    wr_byte(8'h77, 1);
    drain("after_empty_pop");
    chk("final_pop_count", n_pop, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
